// File: rtl/vec_writeback_assembler.sv
// Collects vectorSize memory beats into a lane buffer, then issues one vector register write; scalar writes pass through combinationally and take priority.
// Optional abort input is compiled in when VWB_ABORT_EN is defined.
module vec_writeback_assembler #(
    parameter int registerSize  = 8,
    parameter int vectorSize    = 4,
    parameter int selectionBits = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     start,
    input  logic [selectionBits-1:0]                 destReg,
`ifdef VWB_ABORT_EN
    input  logic                                     abort,
`endif
    input  logic                                     memValid,
    input  logic [registerSize-1:0]                  memData,
    output logic                                     memReady,
    input  logic                                     scWrReq,
    input  logic [selectionBits-1:0]                 scDest,
    input  logic [registerSize-1:0]                  scData,
    output logic                                     regWrEnSc,
    output logic                                     regWrEnVec,
    output logic [selectionBits-1:0]                 regToWrite,
    output logic [vectorSize-1:0][registerSize-1:0]  dataOut_vec,
    output logic [vectorSize-1:0][registerSize-1:0]  dataOut_sc,
    output logic                                     busy,
    output logic                                     done
);
    localparam int CW = (vectorSize > 1) ? $clog2(vectorSize) : 1;
    localparam logic [CW-1:0] LAST = CW'(vectorSize - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;

    state_t                                   r_state;
    state_t                                   w_next;
    logic [CW-1:0]                            r_count;
    logic [vectorSize-1:0][registerSize-1:0]  r_buf;
    logic [selectionBits-1:0]                 r_dest;
    logic                                     w_abort;
    logic                                     w_beat;
    logic                                     w_load;

`ifdef VWB_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort wins over a same-cycle final beat; a pending scalar write holds the vector write in COMMIT.
    always_comb begin
        w_next     = r_state;
        memReady   = 1'b0;
        regWrEnVec = 1'b0;
        done       = 1'b0;
        w_beat     = 1'b0;
        w_load     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = COLLECT;
                end
            end
            COLLECT: begin
                memReady = 1'b1;
                if (w_abort) begin
                    w_next = IDLE;
                end else if (memValid) begin
                    w_beat = 1'b1;
                    if (r_count == LAST) begin
                        w_next = COMMIT;
                    end
                end
            end
            COMMIT: begin
                if (w_abort) begin
                    w_next = IDLE;
                end else if (!scWrReq) begin
                    regWrEnVec = 1'b1;
                    done       = 1'b1;
                    w_next     = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_buf   <= '0;
            r_dest  <= '0;
        end else if (w_load) begin
            r_count <= '0;
            r_buf   <= '0;
            r_dest  <= destReg;
        end else if (w_beat) begin
            r_buf[r_count] <= memData;
            r_count        <= r_count + CW'(1);
        end
    end

    assign regWrEnSc   = scWrReq;
    assign busy        = (r_state != IDLE);
    assign dataOut_vec = r_buf;
    assign regToWrite  = scWrReq ? scDest : (regWrEnVec ? r_dest : '0);

    always_comb begin
        dataOut_sc    = '0;
        dataOut_sc[0] = scData;
    end
endmodule

// File: tb/tb_vec_writeback_assembler.sv
// Randomized self-checking bench for vec_writeback_assembler with a lane-list/latency reference model.
module tb_vec_writeback_assembler;
    logic            clk;
    logic            reset;
    logic            start;
    logic [3:0]      destReg;
    logic            memValid;
    logic [7:0]      memData;
    logic            memReady;
    logic            scWrReq;
    logic [3:0]      scDest;
    logic [7:0]      scData;
    logic            regWrEnSc;
    logic            regWrEnVec;
    logic [3:0]      regToWrite;
    logic [3:0][7:0] dataOut_vec;
    logic [3:0][7:0] dataOut_sc;
    logic            busy;
    logic            done;
`ifdef VWB_ABORT_EN
    logic            abort;
`endif

    int checks = 0;
    int passed = 0;
    logic [7:0] m_elem [4];
    int         m_stall [4];
    int         base_lat = 6;

    vec_writeback_assembler #(.registerSize(8), .vectorSize(4), .selectionBits(4)) dut (
        .clk(clk), .reset(reset), .start(start), .destReg(destReg),
`ifdef VWB_ABORT_EN
        .abort(abort),
`endif
        .memValid(memValid), .memData(memData), .memReady(memReady),
        .scWrReq(scWrReq), .scDest(scDest), .scData(scData),
        .regWrEnSc(regWrEnSc), .regWrEnVec(regWrEnVec), .regToWrite(regToWrite),
        .dataOut_vec(dataOut_vec), .dataOut_sc(dataOut_sc), .busy(busy), .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic next_cycle();
        @(negedge clk);
        start    = 1'b0;
        destReg  = 4'($urandom);
        memValid = 1'b0;
        memData  = 8'($urandom);
        scWrReq  = 1'b0;
        scDest   = 4'($urandom);
        scData   = 8'($urandom);
`ifdef VWB_ABORT_EN
        abort    = 1'b0;
`endif
    endtask

    // Drives one load from m_elem/m_stall; lat counts start cycle through write cycle inclusive.
    task automatic run_load(input logic [3:0] dest, input int sc_cycles, input bit restart,
                            input string tag, output int lat);
        logic [3:0][7:0] exp_vec;
        logic [3:0]      sd;
        logic [7:0]      sdat;
        for (int i = 0; i < 4; i++) exp_vec[i] = m_elem[i];
        next_cycle();
        start = 1'b1; destReg = dest; memValid = 1'b1;
        #1;
        lat = 1;
        checks++;
        if (memReady !== 1'b0 || busy !== 1'b0 || regWrEnVec !== 1'b0)
            $display("FAIL %s start_cycle memReady=%b busy=%b vec=%b required 0/0/0", tag, memReady, busy, regWrEnVec);
        else passed++;
        for (int ln = 0; ln < 4; ln++) begin
            for (int s = 0; s < m_stall[ln]; s++) begin
                next_cycle();
                #1;
                lat++;
                checks++;
                if (memReady !== 1'b1 || busy !== 1'b1 || regWrEnVec !== 1'b0)
                    $display("FAIL %s stall lane%0d memReady=%b busy=%b vec=%b required 1/1/0", tag, ln, memReady, busy, regWrEnVec);
                else passed++;
            end
            next_cycle();
            memValid = 1'b1; memData = m_elem[ln];
            if (restart && ln == 1) begin
                start = 1'b1; destReg = 4'h5;
            end
            #1;
            lat++;
            checks++;
            if (memReady !== 1'b1 || regWrEnVec !== 1'b0 || done !== 1'b0)
                $display("FAIL %s beat lane%0d memReady=%b vec=%b done=%b required 1/0/0", tag, ln, memReady, regWrEnVec, done);
            else passed++;
        end
        for (int k = 0; k < sc_cycles; k++) begin
            next_cycle();
            scWrReq = 1'b1; memValid = 1'b1;
            sd = scDest; sdat = scData;
            #1;
            lat++;
            checks++;
            if (regWrEnSc !== 1'b1 || regWrEnVec !== 1'b0 || memReady !== 1'b0)
                $display("FAIL %s sc_hold%0d sc=%b vec=%b memReady=%b required 1/0/0", tag, k, regWrEnSc, regWrEnVec, memReady);
            else passed++;
            checks++;
            if (regToWrite !== sd || dataOut_sc !== {24'h0, sdat})
                $display("FAIL %s sc_data%0d reg=%h data=%h required %h/%h", tag, k, regToWrite, dataOut_sc, sd, {24'h0, sdat});
            else passed++;
        end
        next_cycle();
        memValid = 1'b1;
        #1;
        lat++;
        checks++;
        if (regWrEnVec !== 1'b1 || done !== 1'b1 || regWrEnSc !== 1'b0)
            $display("FAIL %s write_strobe vec=%b done=%b sc=%b required 1/1/0", tag, regWrEnVec, done, regWrEnSc);
        else passed++;
        checks++;
        if (regToWrite !== dest)
            $display("FAIL %s write_reg got %h required %h", tag, regToWrite, dest);
        else passed++;
        checks++;
        if (dataOut_vec !== exp_vec)
            $display("FAIL %s write_data got %h required %h", tag, dataOut_vec, exp_vec);
        else passed++;
        next_cycle();
        #1;
        checks++;
        if (busy !== 1'b0 || regWrEnVec !== 1'b0 || done !== 1'b0 || regToWrite !== 4'h0)
            $display("FAIL %s after_write busy=%b vec=%b done=%b reg=%h required 0/0/0/0", tag, busy, regWrEnVec, done, regToWrite);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        next_cycle();
        #1;
        checks++;
        if (busy !== 1'b0 || memReady !== 1'b0 || regWrEnVec !== 1'b0 || done !== 1'b0 ||
            regToWrite !== 4'h0 || dataOut_vec !== 32'h0)
            $display("FAIL reset_state busy=%b rdy=%b vec=%b done=%b reg=%h data=%h required all 0",
                     busy, memReady, regWrEnVec, done, regToWrite, dataOut_vec);
        else passed++;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        m_elem[0] = 8'h11; m_elem[1] = 8'h22; m_elem[2] = 8'h33; m_elem[3] = 8'h44;
        for (int i = 0; i < 4; i++) m_stall[i] = 0;
        run_load(4'h2, 0, 1'b0, "basic", lat);
        checks++;
        if (lat !== base_lat) $display("FAIL basic_latency got %0d required %0d", lat, base_lat);
        else passed++;
    endtask

    task automatic test_stall();
        int lat;
        m_elem[0] = 8'h11; m_elem[1] = 8'h22; m_elem[2] = 8'h33; m_elem[3] = 8'h44;
        for (int i = 0; i < 4; i++) m_stall[i] = 0;
        m_stall[1] = 3;
        run_load(4'h2, 0, 1'b0, "stall", lat);
        checks++;
        if (lat !== base_lat + 3) $display("FAIL stall_latency got %0d required %0d", lat, base_lat + 3);
        else passed++;
    endtask

    task automatic test_scalar_commit();
        int lat;
        m_elem[0] = 8'hA1; m_elem[1] = 8'hB2; m_elem[2] = 8'hC3; m_elem[3] = 8'hD4;
        for (int i = 0; i < 4; i++) m_stall[i] = 0;
        run_load(4'h3, 2, 1'b0, "sc_commit", lat);
        checks++;
        if (lat !== base_lat + 2) $display("FAIL sc_commit_latency got %0d required %0d", lat, base_lat + 2);
        else passed++;
    endtask

    task automatic test_scalar_idle();
        next_cycle();
        scWrReq = 1'b1; scDest = 4'h9; scData = 8'hAB; memValid = 1'b1;
        #1;
        checks++;
        if (regWrEnSc !== 1'b1 || regWrEnVec !== 1'b0 || regToWrite !== 4'h9 ||
            dataOut_sc !== 32'h0000_00AB || memReady !== 1'b0)
            $display("FAIL sc_idle sc=%b vec=%b reg=%h data=%h rdy=%b required 1/0/9/000000ab/0",
                     regWrEnSc, regWrEnVec, regToWrite, dataOut_sc, memReady);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int lat;
        next_cycle();
        start = 1'b1; destReg = 4'hC;
        for (int ln = 0; ln < 2; ln++) begin
            next_cycle();
            memValid = 1'b1; memData = 8'hE0 + 8'(ln);
        end
        next_cycle();
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || memReady !== 1'b0 || regWrEnVec !== 1'b0 || done !== 1'b0 || dataOut_vec !== 32'h0)
            $display("FAIL reset_mid busy=%b rdy=%b vec=%b done=%b data=%h required 0/0/0/0/0",
                     busy, memReady, regWrEnVec, done, dataOut_vec);
        else passed++;
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            memValid = 1'b1;
            #1;
            checks++;
            if (regWrEnVec !== 1'b0 || busy !== 1'b0)
                $display("FAIL reset_mid_quiet cyc%0d vec=%b busy=%b required 0/0", c, regWrEnVec, busy);
            else passed++;
        end
        m_elem[0] = 8'h5A; m_elem[1] = 8'h6B; m_elem[2] = 8'h7C; m_elem[3] = 8'h8D;
        for (int i = 0; i < 4; i++) m_stall[i] = 0;
        run_load(4'h6, 0, 1'b0, "after_reset", lat);
    endtask

    task automatic test_restart();
        int lat;
        m_elem[0] = 8'h01; m_elem[1] = 8'h02; m_elem[2] = 8'h03; m_elem[3] = 8'h04;
        for (int i = 0; i < 4; i++) m_stall[i] = 0;
        run_load(4'hA, 0, 1'b1, "restart", lat);
        checks++;
        if (lat !== base_lat) $display("FAIL restart_latency got %0d required %0d", lat, base_lat);
        else passed++;
    endtask

    task automatic test_random();
        int lat;
        int exp_lat;
        int sc;
        logic [3:0] dest;
        bit rs;
        for (int n = 0; n < 20; n++) begin
            exp_lat = base_lat;
            for (int i = 0; i < 4; i++) begin
                m_elem[i]  = 8'($urandom);
                m_stall[i] = int'($urandom_range(3, 0));
                exp_lat += m_stall[i];
            end
            sc   = int'($urandom_range(2, 0));
            dest = 4'($urandom);
            rs   = 1'($urandom);
            exp_lat += sc;
            run_load(dest, sc, rs, "random", lat);
            checks++;
            if (lat !== exp_lat) $display("FAIL random_latency load%0d got %0d required %0d", n, lat, exp_lat);
            else passed++;
        end
    endtask

`ifdef VWB_ABORT_EN
    task automatic test_abort();
        next_cycle();
        start = 1'b1; destReg = 4'h7;
        for (int ln = 0; ln < 3; ln++) begin
            next_cycle();
            memValid = 1'b1; memData = 8'h30 + 8'(ln);
        end
        next_cycle();
        memValid = 1'b1; memData = 8'h33; abort = 1'b1;
        #1;
        checks++;
        if (regWrEnVec !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_cycle vec=%b done=%b required 0/0", regWrEnVec, done);
        else passed++;
        next_cycle();
        #1;
        checks++;
        if (busy !== 1'b0 || memReady !== 1'b0)
            $display("FAIL abort_idle busy=%b rdy=%b required 0/0", busy, memReady);
        else passed++;
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            #1;
            checks++;
            if (regWrEnVec !== 1'b0 || done !== 1'b0)
                $display("FAIL abort_quiet cyc%0d vec=%b done=%b required 0/0", c, regWrEnVec, done);
            else passed++;
        end
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; destReg = 4'h0; memValid = 1'b0; memData = 8'h0;
        scWrReq = 1'b0; scDest = 4'h0; scData = 8'h0;
`ifdef VWB_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_basic();
        test_stall();
        test_scalar_commit();
        test_scalar_idle();
        test_reset_mid();
        test_restart();
        test_random();
`ifdef VWB_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
